uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-byte receiver for the UART link; the far end of uart_transmitter (8N1, LSB first, idle high).
//  Sits between the board RX pin and the command logic. Oversamples with the system clock, checks the stop bit,
//  and queues received bytes in a FIFO drained through a valid/ready byte interface.
// PARAMETERS
//  BAUD_RATE  115200    serial bit rate
//  CLK_FREQ   50000000  clk frequency in Hz; BIT_PERIOD = CLK_FREQ/BAUD_RATE (integer), HALF_PERIOD = BIT_PERIOD/2
//  FIFO_DEPTH 16        received-byte buffer depth; power of two, >= 2
// PORTS
//  clk        in   1  system clock
//  rstn       in   1  asynchronous active-low reset
//  uart_rx    in   1  serial input, asynchronous to clk
//  rx_valid   out  1  FIFO head byte available
//  rx_tdata   out  8  FIFO head byte; stable while rx_valid && !rx_ready
//  rx_ready   in   1  consumer accepts head byte when rx_valid && rx_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  overflow   out  1  1-cycle pulse: good byte arrived with FIFO full, byte discarded
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): sync flops=1, FSM=IDLE, counters=0, FIFO empty; rx_valid=0,
//    rx_tdata=0, frame_err=0, overflow=0. Partial frame is dropped; the first frame after release is received normally.
//  - uart_rx passes through a 2-flop synchroniser (reset value 1); rx_s = 2nd stage, rx_d = rx_s delayed 1 cycle.
//  - FSM IDLE->START->DATA->STOP->IDLE; clk_cnt [15:0] counts within a bit, bit_cnt [2:0] counts data bits.
//  - IDLE: on falling edge (rx_d=1, rx_s=0) clear clk_cnt, go START. A line held low never re-triggers.
//  - START: at clk_cnt==HALF_PERIOD-1 sample; 1 = glitch -> IDLE, no flags; 0 -> clear clk_cnt, bit_cnt, go DATA.
//  - DATA: at clk_cnt==BIT_PERIOD-1 sample and shift in LSB first (shreg <= {s, shreg[7:1]}), clk_cnt->0;
//    after bit_cnt==7 go STOP. Sampling instants are therefore bit centres.
//  - STOP: at clk_cnt==BIT_PERIOD-1 sample; 1 -> push shreg (or overflow pulse if full) -> IDLE;
//    0 -> frame_err pulse, no push -> IDLE (waits for the line to return high before the next edge).
//  - Any number of idle bit periods between frames is accepted, including the transmitter's 5 trailing high bits.
//  - FIFO: push from FSM, pop on rx_valid && rx_ready. rx_valid rises the cycle after a push into an empty FIFO.
//    Push and pop in the same cycle when full: both succeed, no overflow. Pointers wrap mod FIFO_DEPTH;
//    count width $clog2(FIFO_DEPTH+1). Bytes leave in arrival order.
//  - Latency: last falling edge of uart_rx to rx_valid = 2 (sync) + HALF_PERIOD + 9*BIT_PERIOD + 1 clocks, +/-1.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample (start, data, stop) is the 2-of-3 majority of rx_s taken at the
//    target count -1, the target count, and the target count +1. The decision is used 1 cycle after the target.
//    BIT_PERIOD >= 4 is required and is checked by an elaboration assertion.
//  Undefined: a single rx_s sample at the target count; no extra logic.
// STRUCTURE
//  uart_pkg: rx_state_t enum {IDLE,START,DATA,STOP}; constant function bit_period(CLK_FREQ,BAUD_RATE).
//  Sub-module uart_rx_fifo: sync FIFO, params WIDTH=8, DEPTH; ports clk, rstn, push, wdata, full, pop, rdata, empty.
//  The top module holds the synchroniser, FSM, counters, shift register and the flag pulses.
// TESTING  (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_PERIOD=10)
//  1 Drive frame 0xA5 with rx_ready=1 -> exactly one rx_valid cycle, rx_tdata=8'hA5, frame_err=overflow=0.
//  2 Hold uart_rx low for 3 cycles, then high -> no rx_valid, no frame_err; FSM back in IDLE.
//  3 Frame 0x3C with stop bit 0 -> one frame_err pulse, no rx_valid; next frame 0x5A is received correctly.
//  4 rx_ready=0, send 17 frames 0x00..0x10 -> overflow pulses once (on 0x10); drain yields 0x00..0x0F in order.
//  5 Loopback from uart_transmitter (same params): burst 0x01,0x80,0xFF,0x7E -> same 4 bytes in order, no errors.
//  6 Assert rstn low mid-DATA of 0xC3, release, send 0x99 -> only 0x99 is delivered.
//    Rerun 1-6 with UART_RX_MAJORITY_EN and a 1-cycle glitch at the centre of each data bit -> identical results.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Clocks per serial bit; integer division, so CLK_FREQ should be a multiple of the baud rate.
  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO between the UART frame decoder and the consumer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array; no reset needed because reads are qualified by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchroniser, frame FSM and a byte FIFO with valid/ready output.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority voting around every bit-centre sample.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_tdata,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;

  logic       sync_q;
  logic       rx_s;
  logic       rx_d;
  logic       bit_sample;
  rx_state_t  state;
  logic [15:0] clk_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       push_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs one extra cycle, so the whole frame timing runs one clock later.
  localparam int SAMPLE_SKEW = 1;

  logic [1:0] hist;

  if (BIT_PERIOD < 4) begin : g_period_check
    $error("uart_receiver: majority sampling needs BIT_PERIOD >= 4");
  end

  // Keep the two previous synchronised samples for the 2-of-3 vote.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam int SAMPLE_SKEW = 0;

  assign bit_sample = rx_s;
`endif

  localparam logic [15:0] START_LAST = 16'(HALF_PERIOD - 1 + SAMPLE_SKEW);
  localparam logic [15:0] BIT_LAST   = 16'(BIT_PERIOD - 1);

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
    end
  end

  // Frame FSM: finds the start edge, samples bit centres and flags good or bad frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == START_LAST) begin
            if (bit_sample) begin
              state <= IDLE;
            end else begin
              clk_cnt <= '0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            shreg   <= {bit_sample, shreg[7:1]};
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_sample) begin
              push_q <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A good byte is lost only if the FIFO is full and nobody drains it in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else begin
      overflow <= push_q && fifo_full && !fifo_pop;
    end
  end

  assign rx_valid = !fifo_empty;
  assign fifo_pop = rx_valid && rx_ready;
  assign rx_tdata = rx_valid ? fifo_rdata : 8'h00;

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_q),
    .wdata(shreg),
    .full (fifo_full),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty)
  );

endmodule
